// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter and its prescaler.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescale.sv
// Enable prescaler: tick fires on every PRESCALE-th enabled cycle.
// With PRESCALE=1 it is a plain wire from en to tick.
module counter_prescale
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_ps;
            assign unused_ps = ^{clk, clr, sync_clr};
            assign tick      = en;
        end else begin : g_div
            localparam int PW = clog2(PRESCALE);
            localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] ps_q;
            logic [PW-1:0] ps_d;

            assign tick = en && (ps_q == PS_LAST);

            always_comb begin
                ps_d = ps_q;
                if (sync_clr) begin
                    ps_d = '0;
                end else if (tick) begin
                    ps_d = '0;
                end else if (en) begin
                    ps_d = ps_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (clr) begin
                    ps_q <= '0;
                end else begin
                    ps_q <= ps_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with prescaler, clamped load and terminal-count pulse.
// Optional saturate mode (sat port) when MOD_COUNTER_SAT_EN is defined.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // One extra bit so MODULUS = 2^WIDTH does not overflow the compare.
    localparam logic [WIDTH:0] CNT_MAX = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic [WIDTH:0]   count_d;
    logic             tc_d;
    logic             tick;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_ext;
    logic             unused_msb;

    counter_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .sync_clr (load),
        .tick     (tick)
    );

    assign cnt_ext  = {1'b0, count_q};
    assign load_ext = {1'b0, load_val};

    always_comb begin
        count_d = cnt_ext;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_ext > CNT_MAX) ? CNT_MAX : load_ext;
        end else if (tick) begin
            if (up_dn == DIR_UP) begin
                if (cnt_ext == CNT_MAX) begin
                    tc_d    = 1'b1;
                    count_d = '0;
`ifdef MOD_COUNTER_SAT_EN
                    if (sat) begin
                        count_d = CNT_MAX;
                    end
`endif
                end else begin
                    count_d = cnt_ext + 1'b1;
                end
            end else begin
                if (cnt_ext == '0) begin
                    tc_d    = 1'b1;
                    count_d = CNT_MAX;
`ifdef MOD_COUNTER_SAT_EN
                    if (sat) begin
                        count_d = '0;
                    end
`endif
                end else begin
                    count_d = cnt_ext - 1'b1;
                end
            end
        end
    end

    assign unused_msb = count_d[WIDTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d[WIDTH-1:0];
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three configurations driven in parallel.
// Saturate checks compile in when MOD_COUNTER_SAT_EN is defined.
module tb_mod_counter;

    logic       clk;
    logic       clr;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic       sat;
    logic [3:0] count_a, count_b, count_c;
    logic       tc_a, tc_b, tc_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         idx;
        logic [3:0] cnt;
        logic       tc;
    } exp_t;

    exp_t sb[$];

    // Reference model state per instance: a=(M10,P1) b=(M10,P3) c=(M16,P1).
    int m_mod [3] = '{10, 10, 16};
    int m_ps  [3] = '{1, 3, 1};
    int m_cnt [3];
    int m_tc  [3];
    int m_pre [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
        .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_SAT_EN
        .sat(sat),
`endif
        .count(count_a), .tc(tc_a)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
        .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_SAT_EN
        .sat(sat),
`endif
        .count(count_b), .tc(tc_b)
    );

    mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut_c (
        .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_SAT_EN
        .sat(sat),
`endif
        .count(count_c), .tc(tc_c)
    );

    task automatic model_update(input int i);
        logic sat_m;
        logic tick;
`ifdef MOD_COUNTER_SAT_EN
        sat_m = sat;
`else
        sat_m = 1'b0;
`endif
        m_tc[i] = 0;
        if (clr) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
        end else if (load) begin
            m_cnt[i] = (int'(load_val) > m_mod[i] - 1) ? m_mod[i] - 1 : int'(load_val);
            m_pre[i] = 0;
        end else if (en) begin
            tick = (m_pre[i] == m_ps[i] - 1);
            m_pre[i] = tick ? 0 : m_pre[i] + 1;
            if (tick) begin
                if (up_dn) begin
                    if (m_cnt[i] == m_mod[i] - 1) begin
                        m_tc[i]  = 1;
                        m_cnt[i] = sat_m ? m_mod[i] - 1 : 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else begin
                    if (m_cnt[i] == 0) begin
                        m_tc[i]  = 1;
                        m_cnt[i] = sat_m ? 0 : m_mod[i] - 1;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed tc/count=%0b/%0d expected tc/count=%0b/%0d",
                   tag, obs[4], obs[3:0], exp[4], exp[3:0]);
        end
    endtask

    // One clock: push model expectations, clock the DUTs, pop and compare.
    task automatic cyc(input string tag);
        exp_t e;
        logic [4:0] act;
        for (int i = 0; i < 3; i++) begin
            model_update(i);
            e.idx = i;
            e.cnt = m_cnt[i][3:0];
            e.tc  = (m_tc[i] != 0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.idx)
                0:       act = {tc_a, count_a};
                1:       act = {tc_b, count_b};
                default: act = {tc_c, count_c};
            endcase
            chk($sformatf("%s[%0d]", tag, e.idx), act, {e.tc, e.cnt});
        end
    endtask

    task automatic cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) cyc(tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 0;
            m_pre[i] = 0;
        end
        clr = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd7; sat = 1'b0;
        @(posedge clk); #1;
        cycles("reset", 2);
        chk("reset_a", {tc_a, count_a}, 5'd0);
        chk("reset_b", {tc_b, count_b}, 5'd0);

        // Up run through the wrap on modulus 10
        clr = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
        cycles("up_run", 9);
        chk("up_at_9", {tc_a, count_a}, {1'b0, 4'd9});
        cyc("up_wrap");
        chk("up_wrap_tc", {tc_a, count_a}, {1'b1, 4'd0});
        cyc("up_after");
        chk("up_after_wrap", {tc_a, count_a}, {1'b0, 4'd1});

        // Down from zero
        clr = 1'b1; cyc("clr");
        clr = 1'b0; up_dn = 1'b0;
        cyc("down_wrap");
        chk("down_wrap_tc", {tc_a, count_a}, {1'b1, 4'd9});
        cyc("down_next");
        chk("down_next", {tc_a, count_a}, {1'b0, 4'd8});

        // Prescale phases with an enable gap mid-phase
        clr = 1'b1; cyc("clr");
        clr = 1'b0; up_dn = 1'b1;
        cycles("ps_run", 4);
        en = 1'b0; cycles("ps_gap", 2);
        en = 1'b1; cycles("ps_resume", 2);
        chk("ps_delayed", {tc_b, count_b}, {1'b0, 4'd2});
        cycles("ps_run2", 3);

        // Clamped load and clr-over-load
        en = 1'b0; load = 1'b1; load_val = 4'd12;
        cyc("load12");
        chk("load_clamp", {tc_a, count_a}, {1'b0, 4'd9});
        chk("load_noclamp", {tc_c, count_c}, {1'b0, 4'd12});
        clr = 1'b1;
        cyc("load_clr");
        chk("load_clr", {tc_a, count_a}, 5'd0);
        clr = 1'b0;

        // Full-range modulus 16 wrap
        load_val = 4'd15; cyc("load15");
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        cyc("m16_wrap");
        chk("m16_wrap", {tc_c, count_c}, {1'b1, 4'd0});
        en = 1'b0; cycles("hold", 2);
        chk("hold_tc0", {tc_c, count_c}, {1'b0, 4'd0});

`ifdef MOD_COUNTER_SAT_EN
        sat = 1'b1; load = 1'b1; load_val = 4'd9; cyc("sat_load");
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        cyc("sat_up1");
        chk("sat_hold1", {tc_a, count_a}, {1'b1, 4'd9});
        cyc("sat_up2");
        chk("sat_hold2", {tc_a, count_a}, {1'b1, 4'd9});
        sat = 1'b0;
        cyc("sat_off");
        chk("sat_off_wrap", {tc_a, count_a}, {1'b1, 4'd0});
        up_dn = 1'b0; sat = 1'b1;
        cyc("sat_dn");
        chk("sat_dn_hold", {tc_a, count_a}, {1'b1, 4'd0});
        sat = 1'b0;
`endif

        // Random mix against the model
        for (int k = 0; k < 200; k++) begin
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = ($urandom_range(0, 7) != 0) ? up_dn : ~up_dn;
            load     = ($urandom_range(0, 15) == 0);
            clr      = ($urandom_range(0, 31) == 0);
            load_val = 4'($urandom_range(0, 15));
`ifdef MOD_COUNTER_SAT_EN
            sat      = ($urandom_range(0, 3) == 0);
`endif
            cyc("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the counter bit width (1..32).
REQ-002 SHALL have parameter MODULUS, default 16, meaning the count range 0..MODULUS-1; legal values are 2..2^WIDTH.
REQ-003 SHALL have parameter PRESCALE, default 1, meaning the number of enabled cycles per count step (1..65536).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: count enable; feeds the prescaler.
REQ-007 SHALL have port up_dn, input, 1 bit: direction; 1 = up, 0 = down.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH bits: the value to load.
REQ-010 SHALL have port sat, input, 1 bit, only with MOD_COUNTER_SAT_EN: 1 = saturate, 0 = wrap.
REQ-011 SHALL have port count, output, WIDTH bits: the registered count value.
REQ-012 SHALL have port tc, output, 1 bit: registered terminal-count pulse.

Function
REQ-013 Priority per edge SHALL be clr > load > step; at most one action per cycle.
REQ-014 A step SHALL occur only on a prescaler tick: tick = en AND (prescale counter == PRESCALE-1).
REQ-015 The prescale counter SHALL increment on en, wrap to 0 on tick, hold when en=0, and clear on clr or load.
REQ-016 PRESCALE=1 SHALL make tick equal to en, giving zero added latency.
REQ-017 Up step: count < MODULUS-1 -> count+1; count == MODULUS-1 -> 0 (wrap).
REQ-018 Down step: count > 0 -> count-1; count == 0 -> MODULUS-1 (wrap).
REQ-019 A step that crosses a boundary (REQ-017/018 wrap case) SHALL drive tc=1 for exactly the next cycle, coincident with the new count value; tc SHALL be 0 otherwise.
REQ-020 Load SHALL set count = load_val when load_val <= MODULUS-1, else MODULUS-1 (clamp), with tc=0, taking effect the cycle after load.
REQ-021 up_dn changes SHALL take effect on the next tick, with no extra latency.
REQ-022 en=0 with load=0 SHALL hold count, hold the prescaler, and drive tc=0.
REQ-023 Arithmetic SHALL be WIDTH+1 bits internally, with no silent overflow when MODULUS = 2^WIDTH.

Reset
REQ-024 clr=1 at a rising edge SHALL set count=0, tc=0 and prescaler=0, overriding load and en.
REQ-025 clr asserted mid-prescale or mid-wrap SHALL discard pending progress; the first step after release needs a full PRESCALE enabled cycles.

Configuration
REQ-026 Macro MOD_COUNTER_SAT_EN defined: the sat port exists, and with sat=1 a boundary-crossing step SHALL hold count at MODULUS-1 (up) or 0 (down) and still pulse tc.
REQ-027 Macro MOD_COUNTER_SAT_EN undefined: the sat port and saturate logic SHALL be absent; behaviour SHALL always be wrap.

Structure
REQ-028 Package counter_pkg SHALL hold the direction constants DIR_UP/DIR_DOWN and a function clog2 used to size the prescaler.
REQ-029 The prescaler SHALL be sub-module counter_prescale (params PRESCALE; ports clk, clr, en, sync_clr, tick), instantiated once; when PRESCALE=1 it SHALL reduce to a wire.

Verification
REQ-030 WIDTH=4, MODULUS=10, PRESCALE=1, up, en=1 from count 0 -> 0..9, then 0; tc=1 only in the cycle count returns to 0.
REQ-031 Down from 0, MODULUS=10 -> count 9, tc=1 one cycle; the next step -> 8, tc=0.
REQ-032 PRESCALE=3, en=1 -> count steps every 3rd cycle; en low for 2 cycles mid-phase -> step delayed by exactly 2 cycles.
REQ-033 load=1, load_val=12, MODULUS=10 -> count=9; load and clr in the same cycle -> count=0.
REQ-034 MOD_COUNTER_SAT_EN defined, sat=1, up at count 9 -> count stays 9 and tc pulses on each tick; with sat=0 -> wraps to 0.
REQ-035 MODULUS=16, WIDTH=4, up at count 15 -> 0 with tc=1, and no X or overflow artefacts.
